// File: rtl/display_pkg.sv
// Shared constants, state type and BCD-to-segment decode for the display controller.
package display_pkg;

    // Digit codes with a meaning beyond 0-9
    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hB;

    // Active-low segment patterns, bit0 = segment a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [0:0] {StIdle, StShow} disp_state_e;

    // 0-9 to standard glyphs, A to dash, B-F blank
    function automatic logic [6:0] bcd_7seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:     seg = 7'b1000000;
            4'd1:     seg = 7'b1111001;
            4'd2:     seg = 7'b0100100;
            4'd3:     seg = 7'b0110000;
            4'd4:     seg = 7'b0011001;
            4'd5:     seg = 7'b0010010;
            4'd6:     seg = 7'b0000010;
            4'd7:     seg = 7'b1111000;
            4'd8:     seg = 7'b0000000;
            4'd9:     seg = 7'b0010000;
            DIG_DASH: seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_blink_gen.sv
// Free-running blink half-period counter with a phase flop; restart forces the on phase.
module display_blink_gen
    import display_pkg::*;
#(
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_blink_on
);

    localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_HALF - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_on;

    // Count modulo BLINK_HALF, toggling the phase on each wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_on  <= 1'b1;
        end else if (i_restart) begin
            r_cnt <= '0;
            r_on  <= 1'b1;
        end else if (r_cnt == CntLast) begin
            r_cnt <= '0;
            r_on  <= ~r_on;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_blink_on = r_on;

endmodule

// File: rtl/display_mux_n.sv
// Multi-source seven-segment controller: captures the lowest-index valid packet, blinks
// masked digits, blanks after inactivity and drives registered active-low segments.
module display_mux_n
    import display_pkg::*;
#(
    parameter int unsigned N_SRC       = 2,
    parameter int unsigned N_DIGITS    = 6,
    parameter int unsigned BLINK_HALF  = 25_000_000,
    parameter int unsigned TIMEOUT_CYC = 0,
    localparam int unsigned SrcW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_SRC-1:0]             i_src_valid,
    input  logic [N_SRC*4*N_DIGITS-1:0]  i_src_bcd,
    input  logic [N_SRC*N_DIGITS-1:0]    i_src_blink,
    output logic [7*N_DIGITS-1:0]        o_hex,
    output logic                         o_active,
    output logic [SrcW-1:0]              o_active_src
);

    localparam int unsigned PktW = 4 * N_DIGITS;
    localparam int unsigned TmoW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic                w_any_valid;
    logic [SrcW-1:0]     w_sel_idx;
    logic [PktW-1:0]     w_sel_bcd;
    logic [N_DIGITS-1:0] w_sel_blink;
    logic                w_expire;
    logic                w_blink_on;
    disp_state_e         r_state, w_state_d;
    logic [TmoW-1:0]     r_tmo_cnt;
    logic [PktW-1:0]     r_snap_bcd;
    logic [N_DIGITS-1:0] r_snap_blink;
    logic [SrcW-1:0]     r_src_idx;

    assign w_any_valid = |i_src_valid;

    // Priority encoder: scanning downwards leaves the lowest-index valid source selected
    always_comb begin
        w_sel_idx   = '0;
        w_sel_bcd   = i_src_bcd[PktW-1:0];
        w_sel_blink = i_src_blink[N_DIGITS-1:0];
        for (int s = int'(N_SRC) - 1; s >= 0; s--) begin
            if (i_src_valid[s]) begin
                w_sel_idx   = SrcW'(s);
                w_sel_bcd   = i_src_bcd[s*PktW +: PktW];
                w_sel_blink = i_src_blink[s*N_DIGITS +: N_DIGITS];
            end
        end
    end

    // Next state: a capture always wins over timeout expiry
    always_comb begin
        w_expire  = 1'b0;
        w_state_d = r_state;
        if ((TIMEOUT_CYC != 0) && (r_state == StShow) && (r_tmo_cnt == TmoLast)
            && !w_any_valid) begin
            w_expire = 1'b1;
        end
        if (w_any_valid) begin
            w_state_d = StShow;
        end else if (w_expire) begin
            w_state_d = StIdle;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Inactivity counter: cleared by capture, counts in SHOW and saturates instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_any_valid || w_expire) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == StShow) && (r_tmo_cnt != TmoLast)) begin
            r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
        end
    end

    // Snapshot of the captured packet, blink mask and source index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_bcd   <= {N_DIGITS{4'hF}};
            r_snap_blink <= '0;
            r_src_idx    <= '0;
        end else if (w_any_valid) begin
            r_snap_bcd   <= w_sel_bcd;
            r_snap_blink <= w_sel_blink;
            r_src_idx    <= w_sel_idx;
        end
    end

    display_blink_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink (
        .clk        (clk),
        .rst        (rst),
        .i_restart  (w_any_valid),
        .o_blink_on (w_blink_on)
    );

    assign o_active     = (r_state == StShow);
    assign o_active_src = r_src_idx;

    for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
        logic [3:0] w_digit;
        logic       w_mute;
        logic [6:0] r_hex;

        assign w_digit = r_snap_bcd[d*4 +: 4];
        assign w_mute  = r_snap_blink[d] & ~w_blink_on;

        // Decode and mask one digit into its output register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hex <= SEG_BLANK;
            end else if ((r_state == StShow) && !w_mute) begin
                r_hex <= bcd_7seg(w_digit);
            end else begin
                r_hex <= SEG_BLANK;
            end
        end

        assign o_hex[d*7 +: 7] = r_hex;
    end

endmodule

// File: doc/display_mux_n.md
# display_mux_n

Parametrised multi-source seven-segment display controller for the electronic lock. It replaces the fixed two-source display stage. Each of N_SRC producers (operational, setup, alarm, …) presents an N_DIGITS BCD packet with a valid strobe. The block keeps a snapshot of the most recently captured packet, adds per-digit blinking and an inactivity blank-out, and drives registered active-low segment outputs for the board displays.

## Interface
- N_SRC, 2: number of packet sources, at least 1.
- N_DIGITS, 6: digits per packet and number of displays, at least 1.
- BLINK_HALF, 25_000_000: cycles per blink half-period, at least 1.
- TIMEOUT_CYC, 0: cycles without any valid before the display blanks; 0 disables the timeout.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- src_valid  in  N_SRC  one-cycle capture strobe per source.
- src_bcd  in  N_SRC*4*N_DIGITS  packets, source s at [s*4*N_DIGITS +: 4*N_DIGITS], digit d at [d*4 +: 4].
- src_blink  in  N_SRC*N_DIGITS  per-source, per-digit blink mask, captured with the packet.
- hex  out  7*N_DIGITS  segments, digit d at [d*7 +: 7], active-low, bit0 = segment a.
- active  out  1  display showing a snapshot.
- active_src  out  $clog2(N_SRC) (minimum 1)  index of the source currently shown.

## Operation
- **Snapshot registers:** digits, blink mask and source index.
- **Capture:** on each clk edge where any src_valid bit is 1, capture from the lowest-index valid source. The other simultaneous strobes are dropped.
- **Capture side effects:**
  - set active = 1;
  - clear the timeout counter;
  - restart the blink phase as on, with the blink counter at 0.
- **States:** IDLE (active = 0) and SHOW (active = 1).
  - IDLE → SHOW on capture.
  - SHOW → SHOW on capture; a new packet replaces the old one.
  - SHOW → IDLE when TIMEOUT_CYC ≠ 0 and the timeout counter reaches TIMEOUT_CYC−1 with no valid in that cycle.
  - A valid in the same cycle as timeout expiry wins: the block stays in SHOW.
- **Timeout counter:** counts only in SHOW. It is wide enough for TIMEOUT_CYC and never wraps.
- **Blink counter:** free-running modulo BLINK_HALF. The phase toggles when the counter wraps. During the off phase, digits whose snapshot mask bit is 1 output blank.
- **Decode:**
  - 0–9 map to the standard active-low glyphs: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - 4'hA is a dash, 7'b0111111.
  - 4'hB–4'hF are blank, 7'b1111111.
- **IDLE output:** all digits blank and active_src holds its last value.
- **Reset:**
  - hex all 1s, active = 0, active_src = 0;
  - snapshot digits 4'hF, blink mask 0;
  - timeout counter and blink counter 0, blink phase on.

## Timing
- A valid sampled at edge k updates the snapshot, active and active_src at edge k.
- hex reflects the new snapshot from edge k+1, so hex latency is 2 edges from the strobe. hex is fully registered.
- Going IDLE blanks hex one edge after active falls.
- A blink phase change appears on hex one edge after the counter wraps.
- Valid is held high across consecutive cycles: the block recaptures every cycle and the blink stays in the on phase.
- A reset asserted mid-operation clears everything asynchronously. The first capture after release behaves like a capture from IDLE.

## Structure
- **Package display_pkg:**
  - digit codes DIG_DASH = 4'hA and DIG_BLANK = 4'hB;
  - segment constants SEG_BLANK and SEG_DASH;
  - function bcd_7seg.
- **Sub-module display_blink_gen:** blink counter and phase flop, parameter BLINK_HALF, with a restart input. It outputs blink_on.
- **Top level:** capture priority encoder, state/timeout logic and a generate loop of per-digit decode-and-mask registers.

## Test plan
Parameters for all scenarios: N_SRC = 2, N_DIGITS = 6, BLINK_HALF = 4, TIMEOUT_CYC = 20.
- **Reset:** assert rst mid-run → hex = all 7'h7F, active = 0, active_src = 0 immediately. Stay idle after release.
- **Capture latency:** src 0 valid for 1 cycle with digits 1,2,3,4,5,6 → hex0 = 7'b1111001 two edges later, active = 1, active_src = 0.
- **Simultaneous strobes:** both valid in the same cycle with different packets → the src 0 packet is shown. A src 1 valid on the next cycle → src 1 packet shown, active_src = 1.
- **Blink:** src 1 valid with mask 6'b000001 and digit0 = 8:
  - hex0 alternates 7'b0000000 / 7'b1111111 every 4 cycles;
  - the other digits stay steady;
  - a recapture restarts the phase as on.
- **Timeout:** no valid for 20 cycles after a capture → active falls, hex blanks one edge later. A valid on the expiry cycle keeps active = 1.
- **Special codes:** digits A, B, F → dash 7'b0111111, blank, blank.
